mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port data RAM (WE/ADDRESS/WD/RD, synchronous read) between
//  two requesters: port 0 = cpu data port, port 1 = DMA/vector load-store unit.
//  Round-robin grant, one access per cycle, read data routed back by a
//  registered tag pipeline. Sits between the cpu/DMA and ram in the top level.
// PARAMETERS
//  WIDTH       32  data and address width
//  RD_LATENCY  1   RAM cycles from address to RD valid (1..4)
//  MAX_BURST   4   max consecutive locked beats (ARB_BURST_LOCK_EN only)
// PORTS
//  CLK            in   1      clock, all state on rising edge
//  RESET          in   1      asynchronous, active-low reset
//  REQn_VALID     in   1      n=0,1: access request
//  REQn_WE        in   1      1=write, 0=read
//  REQn_ADDR      in   WIDTH  byte address
//  REQn_WD        in   WIDTH  write data
//  REQn_LOCK      in   1      hold grant for next beat (macro only)
//  REQn_READY     out  1      access accepted this cycle (VALID&&READY)
//  REQn_RVALID    out  1      read data valid on REQn_RD
//  REQn_RD        out  WIDTH  read data, 0 when RVALID=0
//  RAM_WE         out  1      to ram WE
//  RAM_ADDR       out  WIDTH  to ram ADDRESS
//  RAM_WD         out  WIDTH  to ram WD
//  RAM_RD         in   WIDTH  from ram RD
// BEHAVIOUR
//  - Reset (RESET=0): READY, RVALID, RD, RAM_WE = 0; RAM_ADDR/RAM_WD = 0;
//    last_gnt=1 (port 0 wins first); FSM=ARB; burst count=0; tag pipe
//    cleared, so in-flight reads are dropped with no RVALID.
//  - Grant is combinational from current VALIDs + registered state. READYn is
//    high only for the granted port, and only when VALIDn=1. At most one READY per cycle.
//  - RAM_* = granted port's WE/ADDR/WD; with no grant, RAM_WE=0 and ADDR/WD=0.
//  - Round-robin: both valid -> grant !last_gnt; one valid -> grant it;
//    last_gnt updates on every accepted beat. Both continuously valid ->
//    strict alternation 0,1,0,1.
//  - Reads: accepted read pushes {1,id} into RD_LATENCY-deep tag pipe;
//    when it emerges, RVALIDid=1 and RDid=RAM_RD for exactly one cycle.
//    Exact latency = RD_LATENCY cycles after the accept edge; order preserved.
//  - Writes: no response; RAM writes on the accept edge.
//  - Back-to-back reads from alternating ports pipeline at 1 access/cycle.
//  - FSM {ARB, LOCKED}: ARB -> LOCKED when an accepted beat has LOCK=1
//    (macro on); LOCKED: only owner may be granted; other port stalls.
//    LOCKED -> ARB when owner beat has LOCK=0, owner drops VALID, or
//    MAX_BURST beats are done while the other port is valid (forced rotation);
//    count clears on leaving LOCKED.
// CONFIGURATION
//  ARB_BURST_LOCK_EN defined: LOCK inputs honoured, LOCKED state and burst
//  counter built. Undefined: LOCK ports present but ignored, FSM stays in ARB,
//  pure round-robin.
// STRUCTURE
//  mem_arb_pkg: req_id_t (1-bit), arb_state_t enum {ARB, LOCKED},
//  rsp_tag_t struct {valid, id}, MAX_RD_LATENCY=4.
//  Sub-module mem_arb_rsp_pipe: RD_LATENCY-stage rsp_tag_t shift register,
//  async active-low clear.
// TESTING
//  1 Reset held with REQ0_VALID=1 -> all READY/RVALID/RAM_WE=0. After release,
//    port 0 granted first.
//  2 Only REQ0: write 0x10<=0xDEADBEEF, then read 0x10 -> REQ0_RVALID 1 cycle
//    after accept, REQ0_RD=0xDEADBEEF, REQ1_RVALID stays 0.
//  3 Both valid reads for 8 cycles (0x0.., 0x100..) -> grants alternate 0,1,...
//    Each RVALID appears on the right port with the right data.
//  4 Port 0 write 0x20=5 and port 1 read 0x20 in the same cycle -> port 0
//    wins (last_gnt=1). Port 1 accepted next cycle and reads 5.
//  5 Read accepted, RESET pulsed low before RD_LATENCY elapses -> no RVALID
//    after release, RAM_WE=0.
//  6 (ARB_BURST_LOCK_EN) port 1 LOCK=1 for 6 beats, port 0 valid -> port 1 gets
//    4 beats, then port 0 granted. Without macro: strict alternation.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data-RAM arbiter: requester id, FSM state and
// the read-response tag that travels alongside the synchronous RAM read.
package mem_arb_pkg;

  localparam int MAX_RD_LATENCY = 4;

  typedef logic req_id_t;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side bundles for mem_arbiter. The requester drives the
// master modport; the arbiter uses slave on requests and master towards the RAM.
interface mem_req_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             we;
  logic             lock;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wd;
  logic             ready;
  logic             rvalid;
  logic [WIDTH-1:0] rd;

  modport master (output valid, we, lock, addr, wd, input ready, rvalid, rd);
  modport slave  (input valid, we, lock, addr, wd, output ready, rvalid, rd);
endinterface

interface mem_ram_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;

  modport master (output we, addr, wd, input rd);
  modport slave  (input we, addr, wd, output rd);
endinterface

// File: rtl/mem_arb_rsp_pipe.sv
// RD_LATENCY-deep shift register of read tags; the tag leaving the last stage
// lines up with the RAM read data for the access that pushed it.
module mem_arb_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t pipe_q [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data RAM between the cpu
// (port 0) and DMA (port 1). Define ARB_BURST_LOCK_EN to honour LOCK bursts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic      CLK,
  input  logic      RESET,
  mem_req_if.slave  req0,
  mem_req_if.slave  req1,
  mem_ram_if.master ram
);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [1:0]       vld;
  logic             last_gnt_q;
  logic [0:0]       state_q;
  req_id_t          owner_q;
  logic             lock_hold;
  logic             gnt_vld;
  req_id_t          gnt_id;
  logic             sel_we;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wd;
  rsp_tag_t         tag_in;
  rsp_tag_t         tag_out;

  assign vld = {req1.valid, req0.valid};

  // A lock only holds while its owner keeps requesting; otherwise arbitrate now.
  assign lock_hold = (state_q == ST_LOCKED) && vld[owner_q];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!RESET) begin
      gnt_vld = 1'b0;
    end else if (lock_hold) begin
      gnt_vld = 1'b1;
      gnt_id  = owner_q;
    end else if (&vld) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_gnt_q;
    end else if (vld[0]) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (vld[1]) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  assign sel_we   = gnt_id ? req1.we   : req0.we;
  assign sel_addr = gnt_id ? req1.addr : req0.addr;
  assign sel_wd   = gnt_id ? req1.wd   : req0.wd;

  assign req0.ready = gnt_vld && (gnt_id == 1'b0);
  assign req1.ready = gnt_vld && (gnt_id == 1'b1);

  assign ram.we   = gnt_vld && sel_we;
  assign ram.addr = gnt_vld ? sel_addr : '0;
  assign ram.wd   = gnt_vld ? sel_wd   : '0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_gnt_q <= 1'b1;
    end else if (gnt_vld) begin
      last_gnt_q <= gnt_id;
    end
  end

`ifdef ARB_BURST_LOCK_EN
  localparam int CNT_W = $clog2(MAX_BURST + 2);

  logic [CNT_W-1:0] burst_cnt_q;
  logic             lock_in;
  logic             burst_done;

  assign lock_in    = gnt_id ? req1.lock : req0.lock;
  assign burst_done = (burst_cnt_q + 1'b1) >= CNT_W'(MAX_BURST);

  // In LOCKED the owner is granted every cycle it is valid, so lock_in is its LOCK.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_ARB;
      owner_q     <= 1'b0;
      burst_cnt_q <= '0;
    end else if (state_q == ST_ARB) begin
      if (gnt_vld && lock_in) begin
        state_q     <= ST_LOCKED;
        owner_q     <= gnt_id;
        burst_cnt_q <= CNT_W'(1);
      end
    end else if (!vld[owner_q] || !lock_in || (burst_done && vld[~owner_q])) begin
      state_q     <= ST_ARB;
      burst_cnt_q <= '0;
    end else if (burst_cnt_q < CNT_W'(MAX_BURST)) begin
      burst_cnt_q <= burst_cnt_q + 1'b1;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = req0.lock | req1.lock;
  assign state_q     = ST_ARB;
  assign owner_q     = 1'b0;
`endif

  assign tag_in.valid = gnt_vld && !sel_we;
  assign tag_in.id    = gnt_id;

  mem_arb_rsp_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rsp_pipe (
    .clk     (CLK),
    .rst_n   (RESET),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign req0.rvalid = tag_out.valid && (tag_out.id == 1'b0);
  assign req1.rvalid = tag_out.valid && (tag_out.id == 1'b1);
  assign req0.rd     = req0.rvalid ? ram.rd : '0;
  assign req1.rd     = req1.rvalid ? ram.rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-port drivers, a RAM model, and a monitor
// that scores grants, RAM muxing and read responses against queued expectations.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int RD_LATENCY = 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        lock;
    int          delay;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic init_mem;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  beat_t beats0[$];
  beat_t beats1[$];
  beat_t cur_beat [2];
  rsp_t  exp0[$];
  rsp_t  exp1[$];
  int    acc_log[$];
  int    exp_order[$];

  mem_req_if #(.WIDTH(32)) req0_if ();
  mem_req_if #(.WIDTH(32)) req1_if ();
  mem_ram_if #(.WIDTH(32)) ram_if ();

  mem_arbiter #(
    .WIDTH      (32),
    .RD_LATENCY (RD_LATENCY),
    .MAX_BURST  (4)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .req0  (req0_if),
    .req1  (req1_if),
    .ram   (ram_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: word-addressed, preloaded with 0xA000_0000 | word index
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [RD_LATENCY];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (ram_if.we) begin
      mem[ram_if.addr[9:2]] <= ram_if.wd;
    end
    rd_pipe[0] <= mem[ram_if.addr[9:2]];
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_if.rd = rd_pipe[RD_LATENCY-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] exp, input logic lock, input int delay);
    beat_t b;
    b.we = we; b.addr = addr; b.wd = wd; b.exp = exp; b.lock = lock; b.delay = delay;
    return b;
  endfunction

  task automatic set_req(input int n, input beat_t b, input logic v);
    if (n == 0) begin
      req0_if.valid = v; req0_if.we = b.we; req0_if.addr = b.addr;
      req0_if.wd = b.wd; req0_if.lock = b.lock;
    end else begin
      req1_if.valid = v; req1_if.we = b.we; req1_if.addr = b.addr;
      req1_if.wd = b.wd; req1_if.lock = b.lock;
    end
  endtask

  task automatic set_idle(input int n);
    set_req(n, mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0), 1'b0);
  endtask

  task automatic drive_port(input int n);
    beat_t b;
    int    waited;
    logic  r;
    while ((n == 0 && beats0.size() != 0) || (n == 1 && beats1.size() != 0)) begin
      if (n == 0) b = beats0.pop_front();
      else        b = beats1.pop_front();
      repeat (b.delay) begin
        @(negedge clk);
        set_idle(n);
      end
      waited = 0;
      forever begin
        @(negedge clk);
        cur_beat[n] = b;
        set_req(n, b, 1'b1);
        #4;
        r = (n == 0) ? req0_if.ready : req1_if.ready;
        @(posedge clk);
        if (r) break;
        waited++;
        if (waited > 50) begin
          vectors++;
          miscompares++;
          $display("FAIL drive_timeout port %0d: waited %0d cycles, limit 50", n, waited);
          break;
        end
      end
    end
    @(negedge clk);
    set_idle(n);
  endtask

  task automatic run_phase();
    fork
      drive_port(0);
      drive_port(1);
    join
    repeat (RD_LATENCY + 2) @(negedge clk);
  endtask

  task automatic check_order(input string name);
    chk($sformatf("%s_count", name), 32'(acc_log.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < acc_log.size(); i++)
      chk($sformatf("%s_gnt%0d", name, i), 32'(acc_log[i]), 32'(exp_order[i]));
    acc_log.delete();
    exp_order.delete();
  endtask

  task automatic monitor_sample();
    rsp_t        e;
    logic        rv;
    logic [31:0] rd;
    logic        r0, r1;
    int          n;
    for (int p = 0; p < 2; p++) begin
      rv = (p == 0) ? req0_if.rvalid : req1_if.rvalid;
      rd = (p == 0) ? req0_if.rd : req1_if.rd;
      if (rv) begin
        if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
          chk($sformatf("unexpected_rvalid%0d", p), 32'(rv), 32'h0);
        end else begin
          if (p == 0) e = exp0.pop_front();
          else        e = exp1.pop_front();
          chk($sformatf("rd%0d_data", p), rd, e.data);
          chk($sformatf("rd%0d_latency", p), 32'(cyc - e.cyc), 32'(RD_LATENCY));
        end
      end else begin
        chk($sformatf("rd%0d_idle_zero", p), rd, 32'h0);
      end
    end
    r0 = req0_if.ready;
    r1 = req1_if.ready;
    chk("one_ready", 32'(r0 & r1), 32'h0);
    chk("ready_needs_valid", 32'((r0 & ~req0_if.valid) | (r1 & ~req1_if.valid)), 32'h0);
    if (r0 || r1) begin
      n = r1 ? 1 : 0;
      acc_log.push_back(n);
      chk("ram_we", 32'(ram_if.we), 32'(cur_beat[n].we));
      chk("ram_addr", ram_if.addr, cur_beat[n].addr);
      if (cur_beat[n].we) begin
        chk("ram_wd", ram_if.wd, cur_beat[n].wd);
      end else begin
        e.data = cur_beat[n].exp;
        e.cyc  = cyc;
        if (n == 0) exp0.push_back(e);
        else        exp1.push_back(e);
      end
    end else begin
      chk("ram_idle", {ram_if.wd[15:0] | ram_if.addr[15:0], 15'h0, ram_if.we}, 32'h0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      monitor_sample();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    init_mem = 1'b1;
    set_idle(0);
    set_idle(1);
    cur_beat[0] = mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    cur_beat[1] = cur_beat[0];
    repeat (2) @(posedge clk);
    init_mem = 1'b0;

    // T1: reset held with requests pending
    @(negedge clk);
    set_req(0, cur_beat[0], 1'b1);
    set_req(1, mk(1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0), 1'b1);
    repeat (3) begin
      #4;
      chk("rst_ready0", 32'(req0_if.ready), 32'h0);
      chk("rst_ready1", 32'(req1_if.ready), 32'h0);
      chk("rst_rvalid", 32'(req0_if.rvalid | req1_if.rvalid), 32'h0);
      chk("rst_ram_we", 32'(ram_if.we), 32'h0);
      chk("rst_ram_addr", ram_if.addr, 32'h0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    set_idle(0);
    set_idle(1);
    beats0.push_back(mk(1'b0, 32'h000, 32'h0, 32'hA000_0000, 1'b0, 0));
    beats1.push_back(mk(1'b0, 32'h100, 32'h0, 32'hA000_0040, 1'b0, 0));
    exp_order = '{0, 1};
    run_phase();
    check_order("t1");

    // T2: port 0 alone, write then read back
    beats0.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0));
    beats0.push_back(mk(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0));
    exp_order = '{0, 0};
    run_phase();
    check_order("t2");

    // T3: both ports streaming reads
    for (int i = 0; i < 4; i++) begin
      beats0.push_back(mk(1'b0, 32'h000 + 32'(4*i), 32'h0, 32'hA000_0000 + 32'(i), 1'b0, 0));
      beats1.push_back(mk(1'b0, 32'h100 + 32'(4*i), 32'h0, 32'hA000_0040 + 32'(i), 1'b0, 0));
    end
    exp_order = '{1, 0, 1, 0, 1, 0, 1, 0};
    run_phase();
    check_order("t3");

    // T4: make port 1 the last grantee, then collide write(0) with read(1)
    beats1.push_back(mk(1'b1, 32'h40, 32'h7, 32'h0, 1'b0, 0));
    exp_order = '{1};
    run_phase();
    check_order("t4_pre");
    beats0.push_back(mk(1'b1, 32'h20, 32'h5, 32'h0, 1'b0, 0));
    beats1.push_back(mk(1'b0, 32'h20, 32'h0, 32'h5, 1'b0, 0));
    exp_order = '{0, 1};
    run_phase();
    check_order("t4");

    // T5: reset while a read is in flight
    @(negedge clk);
    cur_beat[0] = mk(1'b0, 32'h0, 32'h0, 32'hA000_0000, 1'b0, 0);
    set_req(0, cur_beat[0], 1'b1);
    #4;
    chk("t5_ready0", 32'(req0_if.ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    acc_log.delete();
    @(negedge clk);
    set_idle(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      #4;
      chk("t5_rvalid", 32'(req0_if.rvalid | req1_if.rvalid), 32'h0);
      chk("t5_ram_we", 32'(ram_if.we), 32'h0);
      @(negedge clk);
    end

    // T6: port 1 locked burst of 6 beats while port 0 wants two writes
    for (int i = 0; i < 6; i++)
      beats1.push_back(mk(1'b1, 32'h80 + 32'(4*i), 32'h1000 + 32'(i), 32'h0, 1'b1, 0));
    beats0.push_back(mk(1'b1, 32'h60, 32'h2000, 32'h0, 1'b0, 1));
    beats0.push_back(mk(1'b1, 32'h64, 32'h2001, 32'h0, 1'b0, 0));
`ifdef ARB_BURST_LOCK_EN
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 0};
`else
    exp_order = '{1, 0, 1, 0, 1, 1, 1, 1};
`endif
    run_phase();
    check_order("t6");
    beats0.push_back(mk(1'b0, 32'h80, 32'h0, 32'h1000, 1'b0, 0));
    beats0.push_back(mk(1'b0, 32'h94, 32'h0, 32'h1005, 1'b0, 0));
    beats0.push_back(mk(1'b0, 32'h64, 32'h0, 32'h2001, 1'b0, 0));
    exp_order = '{0, 0, 0};
    run_phase();
    check_order("t6_rb");

    chk("pending_rsp0", 32'(exp0.size()), 32'h0);
    chk("pending_rsp1", 32'(exp1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
